// File: rtl/fxp_div_pkg.sv
// Shared definitions for fixed-point arithmetic blocks: divider FSM states and
// two's-complement saturation limits for an arbitrary operand width.
package fxp_div_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } fxp_div_state_e;

    // Largest positive value representable in 'width' bits: 2^(width-1)-1.
    function automatic logic [63:0] fxp_max_pos(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative value representable in 'width' bits: -2^(width-1), sign-extended to 64 bits.
    function automatic logic [63:0] fxp_min_neg(input int unsigned width);
        return ~fxp_max_pos(width);
    endfunction

endpackage

// File: rtl/fxp_div_step.sv
// One restoring-division step: shift the next numerator bit into the
// partial remainder, trial-subtract the divisor, keep the difference if
// it did not go negative and emit the matching quotient bit.
module fxp_div_step #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] i_rem,
    input  logic         i_bit,
    input  logic [N-1:0] i_divisor,
    output logic [N-1:0] o_rem,
    output logic         o_qbit
);

    logic [N:0] w_shift;
    logic [N:0] w_dsr;

    // Trial subtraction with one guard bit so the shifted remainder never wraps.
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_dsr   = {1'b0, i_divisor};
        o_qbit  = (w_shift >= w_dsr);
        o_rem   = o_qbit ? N'(w_shift - w_dsr) : N'(w_shift);
    end

endmodule

// File: rtl/nano20k_top.sv
// Tang Nano 20K board wrapper: Q4.4 divider with the low quotient bits on the LEDs.
module nano20k_top (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_go,
    input  logic       i_ack,
    input  logic [7:0] i_dividend,
    input  logic [7:0] i_divisor,
    output logic [5:0] o_led,
    output logic [1:0] o_quot_msb,
    output logic       o_idle,
    output logic       o_done,
    output logic       o_dbz,
    output logic       o_ovf
);

    logic [7:0] w_quotient;

    fixed_point_signed_divider #(
        .WIDTH(8),
        .FRAC (4)
    ) u_div (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_valid      (i_go),
        .o_ready      (o_idle),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .o_valid      (o_done),
        .i_ready      (i_ack),
        .o_quotient   (w_quotient),
        .o_div_by_zero(o_dbz),
        .o_overflow   (o_ovf)
    );

    // LEDs show the low six quotient bits; the sign/integer MSBs go to spare pins.
    always_comb begin
        o_led      = w_quotient[5:0];
        o_quot_msb = w_quotient[7:6];
    end

endmodule

// File: rtl/fixed_point_signed_divider.sv
// Signed Q(WIDTH-FRAC).FRAC divider. Operands are converted to magnitudes,
// divided by a bit-serial restoring divider (one quotient bit per cycle),
// then signed and saturated. A zero divisor bypasses the iterations.
module fixed_point_signed_divider
    import fxp_div_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FRAC  = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic             o_div_by_zero,
    output logic             o_overflow
);

    // Magnitude width (holds 2^(WIDTH-1) exactly), numerator/quotient width, counter width.
    localparam int unsigned MW = WIDTH + 1;
    localparam int unsigned NW = WIDTH + FRAC;
    localparam int unsigned CW = $clog2(NW + 1);

    localparam logic [WIDTH-1:0] MaxPos = WIDTH'(fxp_max_pos(WIDTH));
    localparam logic [WIDTH-1:0] MinNeg = WIDTH'(fxp_min_neg(WIDTH));
    localparam logic [NW-1:0]    MaxMag = NW'(fxp_max_pos(WIDTH));
    localparam logic [NW-1:0]    MinMag = NW'(fxp_max_pos(WIDTH) + 64'd1);

    fxp_div_state_e   r_state;
    fxp_div_state_e   w_next;

    logic             r_live;
    logic [MW-1:0]    r_rem;
    logic [NW-1:0]    r_numq;
    logic [MW-1:0]    r_dsr;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic             r_dvd_neg;
    logic             r_valid;
    logic [WIDTH-1:0] r_quotient;
    logic             r_div_by_zero;
    logic             r_overflow;

    logic             w_accept;
    logic [MW-1:0]    w_dvd_ext;
    logic [MW-1:0]    w_dsr_ext;
    logic [MW-1:0]    w_dvd_mag;
    logic [MW-1:0]    w_dsr_mag;
    logic [NW-1:0]    w_num;
    logic             w_dsr_zero;
    logic [MW-1:0]    w_rem_next;
    logic             w_qbit;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;

    fxp_div_step #(
        .N(MW)
    ) u_step (
        .i_rem    (r_rem),
        .i_bit    (r_numq[NW-1]),
        .i_divisor(r_dsr),
        .o_rem    (w_rem_next),
        .o_qbit   (w_qbit)
    );

    // Operand magnitudes and the FRAC-scaled numerator.
    always_comb begin
        w_dvd_ext  = {i_dividend[WIDTH-1], i_dividend};
        w_dsr_ext  = {i_divisor[WIDTH-1], i_divisor};
        w_dvd_mag  = i_dividend[WIDTH-1] ? (MW'(0) - w_dvd_ext) : w_dvd_ext;
        w_dsr_mag  = i_divisor[WIDTH-1] ? (MW'(0) - w_dsr_ext) : w_dsr_ext;
        w_num      = NW'(w_dvd_mag) << FRAC;
        w_dsr_zero = (i_divisor == '0);
        w_accept   = i_valid && (r_state == StIdle) && r_live;
    end

    // Apply the sign to the quotient magnitude and saturate to the output range.
    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        if (r_div_by_zero) begin
            w_result = r_dvd_neg ? MinNeg : MaxPos;
        end else if (r_neg && (r_numq != '0)) begin
            if (r_numq > MinMag) begin
                w_result = MinNeg;
                w_ovf    = 1'b1;
            end else begin
                w_result = WIDTH'(0) - WIDTH'(r_numq);
            end
        end else if (r_numq > MaxMag) begin
            w_result = MaxPos;
            w_ovf    = 1'b1;
        end else begin
            w_result = WIDTH'(r_numq);
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_next = w_dsr_zero ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (r_cnt == CW'(NW - 1)) begin
                    w_next = StDone;
                end
            end
            StDone: begin
                if (r_valid && i_ready) begin
                    w_next = StIdle;
                end
            end
            default: w_next = StIdle;
        endcase
    end

    // Outputs; o_ready stays low until the first edge after reset release.
    always_comb begin
        o_ready       = (r_state == StIdle) && r_live;
        o_valid       = r_valid;
        o_quotient    = r_quotient;
        o_div_by_zero = r_div_by_zero;
        o_overflow    = r_overflow;
    end

    // Datapath: operand capture, iteration, and result registration on the first DONE cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_live        <= 1'b0;
            r_rem         <= '0;
            r_numq        <= '0;
            r_dsr         <= '0;
            r_cnt         <= '0;
            r_neg         <= 1'b0;
            r_dvd_neg     <= 1'b0;
            r_valid       <= 1'b0;
            r_quotient    <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_live <= 1'b1;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_rem         <= '0;
                        r_numq        <= w_num;
                        r_dsr         <= w_dsr_mag;
                        r_cnt         <= '0;
                        r_neg         <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
                        r_dvd_neg     <= i_dividend[WIDTH-1];
                        r_div_by_zero <= w_dsr_zero;
                        r_overflow    <= 1'b0;
                    end
                end
                StCalc: begin
                    // Numerator bits leave at the top while quotient bits enter at the bottom.
                    r_rem  <= w_rem_next;
                    r_numq <= {r_numq[NW-2:0], w_qbit};
                    r_cnt  <= r_cnt + CW'(1);
                end
                StDone: begin
                    if (!r_valid) begin
                        r_valid    <= 1'b1;
                        r_quotient <= w_result;
                        r_overflow <= w_ovf;
                    end else if (i_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_signed_divider.sv
// Directed bench for the Q4.4 signed divider with hand-computed expectations.
module tb_fixed_point_signed_divider;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [7:0] i_dividend = 8'h00;
    logic [7:0] i_divisor = 8'h00;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic [7:0] o_quotient;
    logic       o_div_by_zero;
    logic       o_overflow;

    int n_chk = 0;
    int n_bad = 0;

    fixed_point_signed_divider #(
        .WIDTH(8),
        .FRAC (4)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_quotient   (o_quotient),
        .o_div_by_zero(o_div_by_zero),
        .o_overflow   (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request, measure latency from the accept edge, check result, then consume it.
    task automatic do_req(input string tag, input logic [7:0] dvd, input logic [7:0] dsr,
                          input logic [7:0] exp_q, input logic exp_dbz, input logic exp_ovf,
                          input int exp_lat);
        int lat;
        @(negedge i_clk);
        chk({tag, ".rdy"}, 32'(o_ready), 32'd1);
        i_valid    = 1'b1;
        i_dividend = dvd;
        i_divisor  = dsr;
        @(posedge i_clk);
        #1;
        i_valid    = 1'b0;
        i_dividend = 8'h5A;
        i_divisor  = 8'h00;
        lat = 0;
        while (o_valid !== 1'b1 && lat < 40) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".q"}, 32'(o_quotient), 32'(exp_q));
        chk({tag, ".dbz"}, 32'(o_div_by_zero), 32'(exp_dbz));
        chk({tag, ".ovf"}, 32'(o_overflow), 32'(exp_ovf));
        chk({tag, ".nordy"}, 32'(o_ready), 32'd0);
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        chk({tag, ".cons_v"}, 32'(o_valid), 32'd0);
        chk({tag, ".cons_r"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;

        // Reset state.
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.ready", 32'(o_ready), 32'd0);
        chk("rst.q", 32'(o_quotient), 32'd0);
        chk("rst.flags", 32'({o_div_by_zero, o_overflow}), 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        #1;
        chk("rel.ready_pre", 32'(o_ready), 32'd0);
        @(posedge i_clk);
        #1;
        chk("rel.ready", 32'(o_ready), 32'd1);

        // Main function and boundary cases.
        do_req("v3by1p5", 8'h30, 8'h18, 8'h20, 1'b0, 1'b0, 13);
        do_req("neg3by1p5", 8'hD0, 8'h18, 8'hE0, 1'b0, 1'b0, 13);
        do_req("1by3", 8'h10, 8'h30, 8'h05, 1'b0, 1'b0, 13);
        do_req("m1by3", 8'hF0, 8'h30, 8'hFB, 1'b0, 1'b0, 13);
        do_req("ovf_pos", 8'h70, 8'h01, 8'h7F, 1'b0, 1'b1, 13);
        do_req("ovf_m8", 8'h80, 8'hF0, 8'h7F, 1'b0, 1'b1, 13);
        do_req("m8by1", 8'h80, 8'h10, 8'h80, 1'b0, 1'b0, 13);
        do_req("m8by2", 8'h80, 8'h20, 8'hC0, 1'b0, 1'b0, 13);
        do_req("ovf_neg", 8'h70, 8'hFF, 8'h80, 1'b0, 1'b1, 13);
        do_req("dbz_neg", 8'hD0, 8'h00, 8'h80, 1'b1, 1'b0, 1);
        do_req("dbz_zero", 8'h00, 8'h00, 8'h7F, 1'b1, 1'b0, 1);
        do_req("zero_num", 8'h00, 8'hE8, 8'h00, 1'b0, 1'b0, 13);

        // Backpressure: result held for 5 cycles while a second request is dropped.
        @(negedge i_clk);
        i_valid    = 1'b1;
        i_dividend = 8'h30;
        i_divisor  = 8'h18;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        vcount = 0;
        while (o_valid !== 1'b1 && vcount < 40) begin
            @(posedge i_clk);
            #1;
            vcount++;
        end
        chk("hold.lat", 32'(vcount), 32'd13);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            i_valid    = 1'b1;
            i_dividend = 8'h10;
            i_divisor  = 8'h00;
            @(posedge i_clk);
            #1;
            chk($sformatf("hold%0d.v", i), 32'(o_valid), 32'd1);
            chk($sformatf("hold%0d.q", i), 32'(o_quotient), 32'h20);
            chk($sformatf("hold%0d.f", i), 32'({o_div_by_zero, o_overflow}), 32'd0);
            chk($sformatf("hold%0d.r", i), 32'(o_ready), 32'd0);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        chk("hold.cons_v", 32'(o_valid), 32'd0);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid === 1'b1) vcount++;
        end
        chk("hold.dropped", 32'(vcount), 32'd0);
        chk("hold.idle", 32'(o_ready), 32'd1);

        // Reset in the middle of CALC abandons the operation.
        @(negedge i_clk);
        i_valid    = 1'b1;
        i_dividend = 8'h30;
        i_divisor  = 8'h18;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b0;
        @(posedge i_clk);
        #1;
        chk("mrst.valid", 32'(o_valid), 32'd0);
        chk("mrst.ready", 32'(o_ready), 32'd0);
        chk("mrst.q", 32'(o_quotient), 32'd0);
        chk("mrst.flags", 32'({o_div_by_zero, o_overflow}), 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("mrst.ready_up", 32'(o_ready), 32'd1);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid === 1'b1) vcount++;
        end
        chk("mrst.no_result", 32'(vcount), 32'd0);
        do_req("after_rst", 8'h10, 8'h30, 8'h05, 1'b0, 1'b0, 13);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
